// File: rtl/alpha_block_v3.sv
// Multi-level HDR gain-switch controller: fast attack on loud samples, slow masked-timeout decay.
// Optional build macro ALPHA_FORCE_EN adds force_en/force_level override ports.
module alpha_block_v3 #(
  parameter int DATA_W     = 9,
  parameter int NUM_LEVELS = 4,
  parameter int LVL_W      = $clog2(NUM_LEVELS),
  parameter int TMO_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_sampling,
  input  logic [DATA_W-1:0] hdr_current_value,
  input  logic [DATA_W-1:0] threshold_high,
  input  logic [DATA_W-1:0] threshold_low,
  input  logic [TMO_W-1:0]  timeout_mask,
`ifdef ALPHA_FORCE_EN
  input  logic              force_en,
  input  logic [LVL_W-1:0]  force_level,
`endif
  output logic [LVL_W-1:0]  alpha_level,
  output logic              alpha,
  output logic              level_change,
  output logic [TMO_W-1:0]  low_count
);

  localparam logic [LVL_W-1:0] TOP_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  logic [LVL_W-1:0]  level_reg, level_next;
  logic [TMO_W-1:0]  low_count_reg, low_count_next;
  logic              alpha_reg;
  logic              level_change_reg;

  logic [DATA_W-1:0] mag;
  logic              is_high;
  logic              is_low;
  logic [TMO_W-1:0]  hit_bits;
  logic              mask_hit;
  logic              low_sat;

  // The most-negative input negates to 2^(DATA_W-1), which still fits unsigned.
  assign mag     = hdr_current_value[DATA_W-1] ? (~hdr_current_value + DATA_W'(1))
                                               : hdr_current_value;
  assign is_high = (mag > threshold_high);
  assign is_low  = (mag < threshold_low);

  // A mask bit is satisfied when it is clear or the counter has that bit set.
  genvar gi;
  generate
    for (gi = 0; gi < TMO_W; gi++) begin : g_mask_hit
      assign hit_bits[gi] = ~timeout_mask[gi] | low_count_reg[gi];
    end
  endgenerate

  assign mask_hit = (&hit_bits) && (timeout_mask != '0);
  assign low_sat  = &low_count_reg;

  always_comb begin
    level_next     = level_reg;
    low_count_next = low_count_reg;
    if (enable_sampling) begin
      if (is_high) begin
        low_count_next = '0;
        if (level_reg < TOP_LEVEL)
          level_next = level_reg + LVL_ONE;
      end else if (is_low) begin
        if (mask_hit) begin
          low_count_next = '0;
          if (level_reg != '0)
            level_next = level_reg - LVL_ONE;
        end else if (!low_sat) begin
          low_count_next = low_count_reg + TMO_ONE;
        end
      end else begin
        low_count_next = '0;
      end
    end
`ifdef ALPHA_FORCE_EN
    // Override applies on every edge, independent of the sample tick.
    if (force_en) begin
      level_next     = (force_level > TOP_LEVEL) ? TOP_LEVEL : force_level;
      low_count_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_reg        <= '0;
      low_count_reg    <= '0;
      alpha_reg        <= 1'b0;
      level_change_reg <= 1'b0;
    end else begin
      level_reg        <= level_next;
      low_count_reg    <= low_count_next;
      alpha_reg        <= (level_next != '0);
      level_change_reg <= (level_next != level_reg);
    end
  end

  assign alpha_level  = level_reg;
  assign alpha        = alpha_reg;
  assign level_change = level_change_reg;
  assign low_count    = low_count_reg;

endmodule

// File: tb/tb_alpha_block_v3.sv
// Directed bench for alpha_block_v3: attack, masked decay, boundaries and async reset.
module tb_alpha_block_v3;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [8:0] hdr;
  logic [8:0] th_h;
  logic [8:0] th_l;
  logic [4:0] mask;
  logic [1:0] level;
  logic       alpha;
  logic       lc;
  logic [4:0] low;
`ifdef ALPHA_FORCE_EN
  logic       force_en;
  logic [1:0] force_level;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  alpha_block_v3 dut (
    .clk               (clk),
    .reset             (reset),
    .enable_sampling   (en),
    .hdr_current_value (hdr),
    .threshold_high    (th_h),
    .threshold_low     (th_l),
    .timeout_mask      (mask),
`ifdef ALPHA_FORCE_EN
    .force_en          (force_en),
    .force_level       (force_level),
`endif
    .alpha_level       (level),
    .alpha             (alpha),
    .level_change      (lc),
    .low_count         (low)
  );

  // Reads the pre-edge value, so each one-cycle pulse is counted once.
  always @(posedge clk) if (lc) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One enable cycle in eight; returns 1 time unit after the sampling edge.
  task automatic tick(input logic [8:0] v);
    repeat (7) @(posedge clk);
    @(negedge clk);
    hdr = v;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
  endtask

  task automatic ticks(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    hdr   = '0;
    th_h  = 9'd200;
    th_l  = 9'd50;
    mask  = 5'b10000;
`ifdef ALPHA_FORCE_EN
    force_en    = 1'b0;
    force_level = '0;
`endif
    #12;
    check("rst_level", level, 0);
    check("rst_alpha", alpha, 0);
    check("rst_low", low, 0);
    check("rst_lc", lc, 0);
    @(negedge clk) reset = 1'b1;

    // Mid-run async reset from level 2
    tick(9'd210);
    tick(9'd210);
    check("pre_rst_level", level, 2);
    #2 reset = 1'b0;
    #1;
    check("midrst_level", level, 0);
    check("midrst_alpha", alpha, 0);
    check("midrst_low", low, 0);
    check("midrst_lc", lc, 0);
    @(negedge clk) reset = 1'b1;
    pulses = 0;
    ticks(9'd100, 10);
    check("post_rst_level", level, 0);
    check("post_rst_pulses", pulses, 0);

    // Attack: 1,2,3,3,3
    for (int i = 1; i <= 5; i++) begin
      tick(9'd210);
      check("atk_level", level, (i < 3) ? i : 3);
      check("atk_lc", lc, (i <= 3) ? 1 : 0);
      check("atk_alpha", alpha, 1);
    end
    @(posedge clk) #1;
    check("atk_pulses", pulses, 3);

    // Negative magnitudes
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick(-9'sd205);
    check("neg_high_level", level, 1);
    check("neg_high_lc", lc, 1);
    tick(-9'sd12);
    check("neg_low_level", level, 1);
    check("neg_low_count", low, 1);

    // Decay timing from level 3
    ticks(9'd210, 2);
    check("dec_start_level", level, 3);
    check("dec_start_low", low, 0);
    ticks(9'd40, 16);
    check("dec16_level", level, 3);
    check("dec16_low", low, 16);
    tick(9'd40);
    check("dec17_level", level, 2);
    check("dec17_low", low, 0);
    check("dec17_lc", lc, 1);
    ticks(9'd40, 16);
    check("dec33_level", level, 2);
    tick(9'd40);
    check("dec34_level", level, 1);
    ticks(9'd40, 17);
    check("dec51_level", level, 0);
    check("dec51_alpha", alpha, 0);

    // MID sample restarts the count
    tick(9'd210);
    ticks(9'd40, 9);
    check("mid_pre_low", low, 9);
    tick(9'd70);
    check("mid_low", low, 0);
    check("mid_level", level, 1);
    ticks(9'd40, 16);
    check("mid16_level", level, 1);
    check("mid16_low", low, 16);
    tick(9'd40);
    check("mid17_level", level, 0);

    // Threshold equality is MID
    tick(9'd210);
    tick(9'd40);
    tick(9'd200);
    check("eq_high_level", level, 1);
    check("eq_high_low", low, 0);
    check("eq_high_lc", lc, 0);
    tick(9'd40);
    tick(9'd50);
    check("eq_low_low", low, 0);
    check("eq_low_level", level, 1);
    tick(9'd201);
    check("above_high_level", level, 2);
    tick(9'd49);
    check("below_low_low", low, 1);

    // Decay disabled with zero mask
    mask = 5'b00000;
    ticks(9'd40, 40);
    check("mask0_level", level, 2);
    check("mask0_low", low, 31);
    check("mask0_lc", lc, 0);

    // Inverted thresholds: HIGH wins
    th_l = 9'd250;
    tick(9'd220);
    check("inv_level", level, 3);
    check("inv_low", low, 0);
    check("inv_lc", lc, 1);
    tick(9'h100);
    check("maxneg_level", level, 3);
    check("maxneg_lc", lc, 0);

    // Mask change keeps the count
    th_l = 9'd50;
    mask = 5'b10000;
    tick(9'd40);
    mask = 5'b00011;
    tick(9'd40);
    check("mchg_low2", low, 2);
    tick(9'd40);
    check("mchg_low3", low, 3);
    tick(9'd40);
    check("mchg_level", level, 2);
    check("mchg_low0", low, 0);

`ifdef ALPHA_FORCE_EN
    mask = 5'b10000;
    @(negedge clk);
    force_en    = 1'b1;
    force_level = 2'd0;
    @(posedge clk) #1;
    check("frc0_level", level, 0);
    check("frc0_lc", lc, 1);
    @(negedge clk) force_level = 2'd3;
    @(posedge clk) #1;
    check("frc3_level", level, 3);
    check("frc3_lc", lc, 1);
    @(posedge clk) #1;
    check("frc_hold_lc", lc, 0);
    @(negedge clk) force_en = 1'b0;
    ticks(9'd40, 16);
    check("frc_dec16_level", level, 3);
    tick(9'd40);
    check("frc_dec17_level", level, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alpha_block_v3.md
Name: alpha_block_v3

Overview:
Parametrised successor to the two-state HDR gain-switch controller. It tracks the magnitude of a signed HDR sample stream on sampling-enable ticks and drives a multi-level gain index (alpha_level) instead of a single bit.
- Attack: fast, one level per tick while the magnitude is above threshold_high.
- Decay: slow, one level per masked timeout of consecutive below-threshold_low ticks.
- Sits between the HDR sample path and the analog gain-select logic.

Parameters:
DATA_W, 9, width of hdr_current_value and both thresholds
NUM_LEVELS, 4, number of gain levels (>=2); level 0 = highest gain
LVL_W, $clog2(NUM_LEVELS), width of alpha_level
TMO_W, 5, width of timeout_mask and of the low-sample counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable_sampling  in  1  sample-tick qualifier; state updates only on clk edges where this is 1
hdr_current_value  in  DATA_W  signed two's-complement sample
threshold_high  in  DATA_W  unsigned magnitude attack threshold
threshold_low  in  DATA_W  unsigned magnitude decay threshold
timeout_mask  in  TMO_W  decay timeout pattern
alpha_level  out  LVL_W  current gain level, registered
alpha  out  1  registered; 1 when alpha_level != 0
level_change  out  1  one-cycle pulse when alpha_level changes
low_count  out  TMO_W  current consecutive-low counter (debug/observability)

Behaviour:
- Reset (reset=0, async): alpha_level=0, alpha=0, level_change=0, low_count=0.
- Magnitude:
  - mag = |hdr_current_value| as DATA_W-bit unsigned.
  - Most-negative value maps to 2^(DATA_W-1), which is representable; no saturation needed.
  - Example: -9'sd205 gives mag=205.
- Classification per tick, with priority in this order:
  - HIGH: mag > threshold_high (strict).
  - LOW: mag < threshold_low (strict).
  - MID: otherwise.
  - If threshold_low > threshold_high, HIGH still wins.
- On a clk edge with enable_sampling=1:
  - HIGH:
    - if alpha_level < NUM_LEVELS-1, alpha_level += 1;
    - low_count cleared to 0;
    - at the top level: level held, low_count cleared.
  - MID: low_count cleared to 0; level held.
  - LOW, with timeout_mask != 0:
    - if (low_count & timeout_mask) == timeout_mask: alpha_level -= 1 if > 0, and low_count cleared to 0;
    - otherwise low_count += 1, saturating at all-ones.
    - At level 0 the timeout match only clears low_count; no underflow.
  - LOW, with timeout_mask == 0: decay disabled; low_count increments and saturates; level held.
- Decay timing example: timeout_mask=5'b10000 at level 1 with continuous LOW ticks.
  - low_count reaches 16 after 16 ticks.
  - The 17th LOW tick decays to level 0.
- Update latency:
  - alpha_level and low_count update on the same edge that samples the tick.
  - Outputs are visible one clk after the enable cycle's inputs were presented.
  - Inputs must be stable in the cycle enable_sampling=1.
- enable_sampling=0: all state held; level_change=0.
- level_change:
  - asserted for exactly one clk, on the edge where alpha_level takes a new value;
  - 0 on held or saturated ticks.
- alpha equals (alpha_level != 0) at all times, including after reset.
- Mid-operation reset: immediate return to reset values, with no pulse on level_change. The first tick after deassertion behaves as from a clean start.
- Threshold or mask changes take effect on the next tick; low_count is not cleared by a mask change.

Optional Feature:
Macro ALPHA_FORCE_EN.
- Defined:
  - Adds ports force_en (in, 1) and force_level (in, LVL_W).
  - While force_en=1, on every clk edge regardless of enable_sampling: alpha_level = min(force_level, NUM_LEVELS-1) and low_count=0.
  - level_change pulses if the value changed.
  - Normal tracking resumes on the first tick after force_en falls, starting from the forced level.
- Not defined: ports absent; behaviour exactly as above.

Test Plan:
Defaults, enable_sampling high 1 clk in 8, th_high=200, th_low=50, timeout_mask=5'b10000.
1. Reset check: reset=0 mid-run at level 2 -> alpha_level=0, alpha=0, low_count=0 immediately. hdr=100 for 10 ticks after release -> level stays 0, level_change never pulses.
2. Attack: hdr=210 for 5 ticks -> level 1, 2, 3, 3, 3 on successive ticks. level_change pulses exactly 3 times, alpha=1 from the first tick.
3. Negative magnitude: hdr=-9'sd205 -> treated as HIGH, level +1. hdr=-9'sd12 -> treated as LOW.
4. Decay timing: from level 3, hdr=40 continuous -> level 2 on the 17th tick, level 1 on the 34th, level 0 on the 51st. A MID sample (hdr=70) at tick 10 restarts the count, and the first decay lands 17 ticks after the next LOW.
5. Boundaries:
   - hdr=200 and hdr=50 -> MID, no level change.
   - timeout_mask=0 with hdr=40 for 40 ticks -> level held, low_count saturates at 31.
   - th_low=250, th_high=200, hdr=220 -> attack.
6. ALPHA_FORCE_EN build: force_en=1, force_level=3 with NUM_LEVELS=3 -> level 2 next clk, without an enable tick, and level_change pulses once. Release force_en with hdr=40 -> decay to level 1 on the 17th tick.
